// File: rtl/seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector
//   Serial pattern detector. Watches a 1-bit stream qualified by en and emits a
//   one-cycle registered pulse on every occurrence of PATTERN (MSB received
//   first). Matches may overlap or consume their bits, selected by OVERLAP.
//   A saturating counter tallies matches for status readout.
//
//   Handshake: x_in is sampled only on rising edges where en=1. There is no
//   back-pressure; every en=1 edge consumes exactly one bit.
//
// Parameters
//   PAT_W    pattern length in bits (>= 2)
//   PATTERN  target sequence, MSB = first bit received
//   OVERLAP  1: matches may share bits, 0: bits of a match are consumed
//   CNT_W    match counter width (>= 1)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   en         in   x_in valid this cycle
//   x_in       in   serial data bit
//   clear      in   synchronous clear of match_cnt / cnt_sat
//   y_out      out  registered 1-cycle match pulse
//   match_cnt  out  saturating match count since reset/clear
//   cnt_sat    out  match_cnt is all-ones (sticky until clear/reset)
//   state_o    out  FSM state for debug (EMPTY=0 FILL=1 ARMED=2)
// -----------------------------------------------------------------------------
module seq_pattern_detector #(
    parameter int                PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
    parameter bit                OVERLAP = 1'b1,
    parameter int                CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x_in,
    input  logic             clear,
    output logic             y_out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    localparam int              FW       = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]   FILL_ARM = FW'(PAT_W - 1);
    localparam logic [FW-1:0]   FILL_MAX = FW'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_ALL = {CNT_W{1'b1}};

    state_t           state;
    logic [PAT_W-1:0] sr;
    logic [FW-1:0]    fill;

    logic [PAT_W-1:0] next_sr;
    logic [FW-1:0]    fill_inc;
    logic             match;

    // The match is judged on the window including the bit being shifted in
    // this edge, so the pulse appears one cycle after the last pattern bit.
    assign next_sr  = {sr[PAT_W-2:0], x_in};
    assign fill_inc = (fill == FILL_MAX) ? fill : fill + 1'b1;
    assign match    = en && (state == ARMED) && (next_sr == PATTERN);
    assign state_o  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            sr        <= '0;
            fill      <= '0;
            y_out     <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            y_out <= match;

            // Clear wins over a same-edge increment; the pulse is unaffected.
            if (clear) begin
                match_cnt <= '0;
                cnt_sat   <= 1'b0;
            end else if (match && (match_cnt != CNT_ALL)) begin
                match_cnt <= match_cnt + 1'b1;
                cnt_sat   <= ((match_cnt + 1'b1) == CNT_ALL);
            end

            case (state)
                EMPTY, FILL: begin
                    if (en) begin
                        sr   <= next_sr;
                        fill <= fill_inc;
                        // Armed once PAT_W-1 bits are held: the next bit
                        // completes a full window. Covers PAT_W=2 directly.
                        if (fill_inc == FILL_ARM) state <= ARMED;
                        else                      state <= FILL;
                    end
                end
                ARMED: begin
                    if (en) begin
                        sr <= next_sr;
                        if (!OVERLAP && match) begin
                            // Consume the match: a fresh PAT_W bits are needed.
                            state <= EMPTY;
                            fill  <= '0;
                        end else begin
                            fill <= fill_inc;
                        end
                    end
                end
                default: begin
                    // Unused encoding recovers to a clean empty window.
                    state <= EMPTY;
                    fill  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_detector
//   Directed bench for seq_pattern_detector. Four instances share the stimulus:
//   d0 default, d1 non-overlapping, d2 2-bit counter, d3 PAT_W=2 PATTERN=2'b11.
//   Each step pushes the expected y_out of the instance under test into a queue
//   and pops it once the DUT has produced its registered output.
// -----------------------------------------------------------------------------
module tb_seq_pattern_detector;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_ARMED = 2'd2;

    logic clk;
    logic reset;
    logic en;
    logic x_in;
    logic clear;

    logic       y0, y1, y2, y3;
    logic [7:0] cnt0, cnt1, cnt3;
    logic [1:0] cnt2;
    logic       sat0, sat1, sat2, sat3;
    logic [1:0] st0, st1, st2, st3;

    logic exp_q[$];
    int   total;
    int   bad;

    seq_pattern_detector u_d0 (
        .clk(clk), .reset(reset), .en(en), .x_in(x_in), .clear(clear),
        .y_out(y0), .match_cnt(cnt0), .cnt_sat(sat0), .state_o(st0)
    );

    seq_pattern_detector #(.OVERLAP(1'b0)) u_d1 (
        .clk(clk), .reset(reset), .en(en), .x_in(x_in), .clear(clear),
        .y_out(y1), .match_cnt(cnt1), .cnt_sat(sat1), .state_o(st1)
    );

    seq_pattern_detector #(.CNT_W(2)) u_d2 (
        .clk(clk), .reset(reset), .en(en), .x_in(x_in), .clear(clear),
        .y_out(y2), .match_cnt(cnt2), .cnt_sat(sat2), .state_o(st2)
    );

    seq_pattern_detector #(.PAT_W(2), .PATTERN(2'b11)) u_d3 (
        .clk(clk), .reset(reset), .en(en), .x_in(x_in), .clear(clear),
        .y_out(y3), .match_cnt(cnt3), .cnt_sat(sat3), .state_o(st3)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic y_of(input int d);
        case (d)
            0:       return y0;
            1:       return y1;
            2:       return y2;
            default: return y3;
        endcase
    endfunction

    // One clock of stimulus; inputs change #1 after the edge, outputs sampled
    // #1 after the next edge.
    task automatic step(input int d, input logic b, input logic e,
                        input logic c, input logic ey, input string tag);
        logic want;
        en    = e;
        x_in  = b;
        clear = c;
        exp_q.push_back(ey);
        @(posedge clk);
        #1;
        en    = 1'b0;
        clear = 1'b0;
        want  = exp_q.pop_front();
        check(tag, {31'd0, y_of(d)}, {31'd0, want});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        logic [1:0] held;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        en    = 1'b0;
        x_in  = 1'b0;
        clear = 1'b0;

        // reset state, before any clock edge
        #3;
        check("rst_y",     {31'd0, y0},   0);
        check("rst_cnt",   {24'd0, cnt0}, 0);
        check("rst_sat",   {31'd0, sat0}, 0);
        check("rst_state", {30'd0, st0},  S_EMPTY);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 1) overlapping: 1,0,1,1,0,1,1
        step(0, 1, 1, 0, 0, "t1_b1");
        step(0, 0, 1, 0, 0, "t1_b2");
        step(0, 1, 1, 0, 0, "t1_b3");
        check("t1_armed", {30'd0, st0}, S_ARMED);
        step(0, 1, 1, 0, 1, "t1_b4");
        step(0, 0, 1, 0, 0, "t1_b5");
        step(0, 1, 1, 0, 0, "t1_b6");
        step(0, 1, 1, 0, 1, "t1_b7");
        check("t1_cnt", {24'd0, cnt0}, 2);

        // 2) non-overlapping: 1,0,1,1,0,1,1,1,0,1,1
        do_reset();
        step(1, 1, 1, 0, 0, "t2_b1");
        step(1, 0, 1, 0, 0, "t2_b2");
        step(1, 1, 1, 0, 0, "t2_b3");
        step(1, 1, 1, 0, 1, "t2_b4");
        check("t2_empty", {30'd0, st1}, S_EMPTY);
        step(1, 0, 1, 0, 0, "t2_b5");
        step(1, 1, 1, 0, 0, "t2_b6");
        step(1, 1, 1, 0, 0, "t2_b7");
        step(1, 1, 1, 0, 0, "t2_b8");
        step(1, 0, 1, 0, 0, "t2_b9");
        step(1, 1, 1, 0, 0, "t2_b10");
        step(1, 1, 1, 0, 1, "t2_b11");
        check("t2_cnt", {24'd0, cnt1}, 2);

        // 3) 1011 with three idle cycles (random x_in) after every bit
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic [3:0] pat;
            pat = 4'b1011;
            step(0, pat[3-i], 1, 0, (i == 3), "t3_bit");
            held = st0;
            check("t3_state_after_bit", {30'd0, st0},
                  (i == 0) ? S_FILL : (i == 1) ? S_FILL : S_ARMED);
            for (int k = 0; k < 3; k++) begin
                step(0, 1'($urandom_range(0, 1)), 0, 0, 0, "t3_idle_y");
                check("t3_idle_state", {30'd0, st0}, {30'd0, held});
            end
        end
        check("t3_cnt", {24'd0, cnt0}, 1);

        // 4) 2-bit counter saturation and clear priority
        do_reset();
        step(2, 1, 1, 0, 0, "t4_p1");
        step(2, 0, 1, 0, 0, "t4_p2");
        step(2, 1, 1, 0, 0, "t4_p3");
        step(2, 1, 1, 0, 1, "t4_m1");
        check("t4_cnt1", {30'd0, cnt2}, 1);
        check("t4_sat1", {31'd0, sat2}, 0);
        for (int m = 2; m <= 5; m++) begin
            step(2, 0, 1, 0, 0, "t4_s0");
            step(2, 1, 1, 0, 0, "t4_s1");
            step(2, 1, 1, 0, 1, "t4_m");
            check("t4_cnt", {30'd0, cnt2}, (m < 3) ? m : 3);
            check("t4_sat", {31'd0, sat2}, (m >= 3) ? 1 : 0);
        end
        step(2, 0, 1, 0, 0, "t4_s0");
        step(2, 1, 1, 0, 0, "t4_s1");
        step(2, 1, 1, 1, 1, "t4_m6_clear");
        check("t4_clr_cnt", {30'd0, cnt2}, 0);
        check("t4_clr_sat", {31'd0, sat2}, 0);

        // 5) reset mid-pattern discards partial bits
        do_reset();
        step(0, 1, 1, 0, 0, "t5_b1");
        step(0, 0, 1, 0, 0, "t5_b2");
        step(0, 1, 1, 0, 0, "t5_b3");
        reset = 1'b0;
        #1;
        check("t5_async_state", {30'd0, st0},  S_EMPTY);
        check("t5_async_cnt",   {24'd0, cnt0}, 0);
        #1;
        reset = 1'b1;
        step(0, 1, 1, 0, 0, "t5_b4");
        check("t5_fill", {30'd0, st0}, S_FILL);
        step(0, 0, 1, 0, 0, "t5_b5");
        step(0, 1, 1, 0, 0, "t5_b6");
        step(0, 1, 1, 0, 1, "t5_b7");

        // 6) PAT_W=2, PATTERN=11: 1,1,1,0,1
        do_reset();
        step(3, 1, 1, 0, 0, "t6_b1");
        check("t6_st1", {30'd0, st3}, S_ARMED);
        step(3, 1, 1, 0, 1, "t6_b2");
        check("t6_st2", {30'd0, st3}, S_ARMED);
        step(3, 1, 1, 0, 1, "t6_b3");
        step(3, 0, 1, 0, 0, "t6_b4");
        step(3, 1, 1, 0, 0, "t6_b5");
        check("t6_st5", {30'd0, st3}, S_ARMED);
        check("t6_cnt", {24'd0, cnt3}, 2);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
